// File: rtl/keypad_matrix_emu.sv
// Emulates the key-matrix side of a 4x4 keypad: answers the scanner's active-low
// column drive on the active-low row lines for one requested key, with contact bounce.
module keypad_matrix_emu #(
  parameter int unsigned BOUNCE_PERIOD  = 3,
  parameter int unsigned BOUNCE_TOGGLES = 4,
  parameter int unsigned HOLD_CYCLES    = 64,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_req,
  input  logic [3:0] key_code,
  output logic       busy,
  output logic       done,
  input  logic [3:0] col,
  output logic [3:0] row
);

  localparam int unsigned TOG_W = (BOUNCE_TOGGLES > 0) ? $clog2(BOUNCE_TOGGLES + 1) : 1;
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_PERIOD - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [TOG_W-1:0] TOG_LAST    = TOG_W'(BOUNCE_TOGGLES);
  localparam bit               HAS_BOUNCE  = (BOUNCE_TOGGLES != 0);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_BOUNCE,
    HELD,
    RELEASE_BOUNCE,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TOG_W-1:0] tog_q, tog_d;
  logic             contact_q, contact_d;
  logic [1:0]       col_sel_q, col_sel_d;
  logic [1:0]       row_sel_q, row_sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       row_q, row_d;

  // Physical key position {col, row} for each hex code on the keypad face.
  function automatic logic [3:0] key_to_pos(input logic [3:0] code);
    logic [3:0] pos;
    case (code)
      4'hD: pos = {2'd0, 2'd0};
      4'hC: pos = {2'd0, 2'd1};
      4'hB: pos = {2'd0, 2'd2};
      4'hA: pos = {2'd0, 2'd3};
      4'hF: pos = {2'd1, 2'd0};
      4'h9: pos = {2'd1, 2'd1};
      4'h6: pos = {2'd1, 2'd2};
      4'h3: pos = {2'd1, 2'd3};
      4'h0: pos = {2'd2, 2'd0};
      4'h8: pos = {2'd2, 2'd1};
      4'h5: pos = {2'd2, 2'd2};
      4'h2: pos = {2'd2, 2'd3};
      4'hE: pos = {2'd3, 2'd0};
      4'h7: pos = {2'd3, 2'd1};
      4'h4: pos = {2'd3, 2'd2};
      default: pos = {2'd3, 2'd3};
    endcase
    return pos;
  endfunction

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    tog_d     = tog_q;
    contact_d = contact_q;
    col_sel_d = col_sel_q;
    row_sel_d = row_sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    row_d = 4'hF;
    if (contact_q && !col[col_sel_q]) row_d[row_sel_q] = 1'b0;

    case (state_q)
      IDLE: begin
        contact_d = 1'b0;
        // The done cycle still counts as the tail of the sequence.
        if (key_req && !done_q) begin
          {col_sel_d, row_sel_d} = key_to_pos(key_code);
          cnt_d     = '0;
          tog_d     = '0;
          busy_d    = 1'b1;
          contact_d = 1'b1;
          state_d   = HAS_BOUNCE ? PRESS_BOUNCE : HELD;
        end
      end
      PRESS_BOUNCE: begin
        if (cnt_q == BOUNCE_LAST) begin
          cnt_d = '0;
          if (tog_q == TOG_LAST) begin
            contact_d = 1'b1;
            state_d   = HELD;
          end else begin
            tog_d     = tog_q + 1'b1;
            contact_d = ~contact_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d     = '0;
          tog_d     = '0;
          contact_d = 1'b0;
          state_d   = HAS_BOUNCE ? RELEASE_BOUNCE : GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE_BOUNCE: begin
        if (cnt_q == BOUNCE_LAST) begin
          cnt_d = '0;
          if (tog_q == TOG_LAST) begin
            contact_d = 1'b0;
            state_d   = GAP;
          end else begin
            tog_d     = tog_q + 1'b1;
            contact_d = ~contact_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        contact_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tog_q     <= '0;
      contact_q <= 1'b0;
      col_sel_q <= 2'd0;
      row_sel_q <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      row_q     <= 4'hF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tog_q     <= tog_d;
      contact_q <= contact_d;
      col_sel_q <= col_sel_d;
      row_sel_q <= row_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      row_q     <= row_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign row  = row_q;

endmodule

// File: tb/tb_keypad_matrix_emu.sv
// Bench for keypad_matrix_emu: a bouncing instance (defaults) and a clean-edge instance,
// each checked every cycle against a timeline model plus hand-computed literal points.
module tb_keypad_matrix_emu;

  localparam int PER  [2] = '{3, 2};
  localparam int TOG  [2] = '{4, 0};
  localparam int HOLD [2] = '{64, 8};
  localparam int GAPC [2] = '{16, 5};

  // Keypad face: LAYOUT[col][row]
  localparam logic [3:0] LAYOUT [4][4] = '{
    '{4'hD, 4'hC, 4'hB, 4'hA},
    '{4'hF, 4'h9, 4'h6, 4'h3},
    '{4'h0, 4'h8, 4'h5, 4'h2},
    '{4'hE, 4'h7, 4'h4, 4'h1}
  };
  localparam logic [3:0] PAT [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] key_req;
  logic [3:0] key_code [2];
  logic [3:0] col [2];
  logic [3:0] row [2];
  logic [1:0] busy;
  logic [1:0] done;

  always #5 clk = ~clk;

  keypad_matrix_emu u_bounce (
    .clk(clk), .reset(reset), .key_req(key_req[0]), .key_code(key_code[0]),
    .busy(busy[0]), .done(done[0]), .col(col[0]), .row(row[0])
  );

  keypad_matrix_emu #(
    .BOUNCE_PERIOD(PER[1]), .BOUNCE_TOGGLES(TOG[1]),
    .HOLD_CYCLES(HOLD[1]), .GAP_CYCLES(GAPC[1]), .CNT_W(16)
  ) u_clean (
    .clk(clk), .reset(reset), .key_req(key_req[1]), .key_code(key_code[1]),
    .busy(busy[1]), .done(done[1]), .col(col[1]), .row(row[1])
  );

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int plen(input int i);
    return (TOG[i] > 0) ? (TOG[i] + 1) * PER[i] : 0;
  endfunction

  function automatic int busy_len(input int i);
    return 2 * plen(i) + HOLD[i] + GAPC[i];
  endfunction

  // Contact state t cycles into a sequence (t=1 is the first busy cycle).
  function automatic bit contact_at(input int i, input int t);
    int pl = plen(i);
    int h  = HOLD[i];
    if (t <= pl)         return ((t - 1) / PER[i]) % 2 == 0;
    if (t <= pl + h)     return 1'b1;
    if (t <= 2 * pl + h) return ((t - pl - h - 1) / PER[i]) % 2 == 1;
    return 1'b0;
  endfunction

  function automatic int find_pos(input logic [3:0] code);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (LAYOUT[c][r] == code) return c * 4 + r;
    return 0;
  endfunction

  function automatic int zero_idx(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (!v[k]) return k;
    return -1;
  endfunction

  // Key seen by a scanner; bit 4 flags an undecodable pattern.
  function automatic logic [4:0] key_at(input logic [3:0] c_vec, input logic [3:0] r_vec);
    int c = zero_idx(c_vec);
    int r = zero_idx(r_vec);
    if (c < 0 || r < 0) return 5'h10;
    return {1'b0, LAYOUT[c][r]};
  endfunction

  bit         m_busy [2];
  bit         m_done [2];
  int         m_t    [2];
  int         m_c    [2];
  int         m_r    [2];
  logic [3:0] exp_row [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i]  <= 1'b0;
        m_done[i]  <= 1'b0;
        m_t[i]     <= 0;
        m_c[i]     <= 0;
        m_r[i]     <= 0;
        exp_row[i] <= 4'hF;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_row[i] <= (m_busy[i] && contact_at(i, m_t[i]) && !col[i][m_c[i]])
                      ? 4'(~(4'b0001 << m_r[i])) : 4'hF;
        if (m_busy[i]) begin
          if (m_t[i] == busy_len(i)) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
          end else begin
            m_t[i]    <= m_t[i] + 1;
            m_done[i] <= 1'b0;
          end
        end else if (!m_done[i] && key_req[i]) begin
          m_busy[i] <= 1'b1;
          m_done[i] <= 1'b0;
          m_t[i]    <= 1;
          m_c[i]    <= find_pos(key_code[i]) / 4;
          m_r[i]    <= find_pos(key_code[i]) % 4;
        end else begin
          m_done[i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("model_row[%0d]", i), row[i], exp_row[i]);
        check($sformatf("model_busy[%0d]", i), busy[i], m_busy[i]);
        check($sformatf("model_done[%0d]", i), done[i], m_done[i]);
      end
    end
  end

  logic [3:0] tr_row  [0:127];
  logic       tr_busy [0:127];
  logic       tr_done [0:127];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input int i, input logic [3:0] code);
    key_req[i]  = 1'b1;
    key_code[i] = code;
    tick();
    key_req[i]  = 1'b0;
  endtask

  task automatic trace(input int i, input int len);
    tr_row[0]  = row[i];
    tr_busy[0] = busy[i];
    tr_done[0] = done[i];
    for (int n = 1; n <= len; n++) begin
      tick();
      tr_row[n]  = row[i];
      tr_busy[n] = busy[i];
      tr_done[n] = done[i];
    end
  endtask

  task automatic wait_done(input int i, input int budget);
    int k = 0;
    while (done[i] !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check("done_within_budget", done[i], 1'b1);
  endtask

  int         busy_cnt;
  int         hits;
  int         ph;
  logic [3:0] sent;

  initial begin
    reset    = 1'b1;
    key_req  = 2'b00;
    key_code = '{4'h0, 4'h0};
    col      = '{4'hE, 4'hE};
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check("reset_row", row[i], 4'hF);
      check("reset_busy", busy[i], 1'b0);
      check("reset_done", done[i], 1'b0);
    end
    reset  = 1'b0;
    cmp_en = 1'b1;
    tick();

    // Clean edges, key D at (c0,r0), col held 1110.
    press(1, 4'hD);
    trace(1, 14);
    check("clean_row_n0", tr_row[0], 4'hF);
    check("clean_row_n1", tr_row[1], 4'hE);
    check("clean_row_n8", tr_row[8], 4'hE);
    check("clean_row_n9", tr_row[9], 4'hF);
    check("clean_busy_n12", tr_busy[12], 1'b1);
    check("clean_busy_n13", tr_busy[13], 1'b0);
    check("clean_done_n13", tr_done[13], 1'b1);
    check("clean_done_n14", tr_done[14], 1'b0);
    tick();

    // Key 5 at (c2,r2) with a stepping column; a busy-time request for key 7 is ignored.
    col[1] = 4'hF;
    press(1, 4'h5);
    for (int n = 1; n <= 13; n++) begin
      col[1] = PAT[(n - 1) % 4];
      if (n == 5) begin
        key_req[1]  = 1'b1;
        key_code[1] = 4'h7;
      end
      if (n == 6) key_req[1] = 1'b0;
      tick();
      if (n == 3)  check("step_row_col1011", row[1], 4'hB);
      if (n == 4)  check("step_row_col0111", row[1], 4'hF);
      if (n == 7)  check("busy_req_ignored_row", row[1], 4'hB);
      if (n == 11) check("step_row_after_hold", row[1], 4'hF);
    end
    check("step_done_pulse", done[1], 1'b1);
    key_req[1]  = 1'b1;
    key_code[1] = 4'h7;
    tick();
    check("done_cycle_req_ignored", busy[1], 1'b0);
    tick();
    check("req_after_done_accepted", busy[1], 1'b1);
    key_req[1] = 1'b0;
    col[1]     = 4'h7;
    tick();
    check("second_key_row", row[1], 4'hD);
    wait_done(1, 40);
    tick();

    // Default bounce, key 1 at (c3,r3), col held 0111.
    col[0] = 4'h7;
    press(0, 4'h1);
    trace(0, 111);
    check("bounce_row_n0", tr_row[0], 4'hF);
    check("bounce_row_n1", tr_row[1], 4'h7);
    check("bounce_row_n3", tr_row[3], 4'h7);
    check("bounce_row_n4", tr_row[4], 4'hF);
    check("bounce_row_n6", tr_row[6], 4'hF);
    check("bounce_row_n7", tr_row[7], 4'h7);
    check("bounce_row_n10", tr_row[10], 4'hF);
    check("bounce_row_n13", tr_row[13], 4'h7);
    check("bounce_row_n79", tr_row[79], 4'h7);
    check("bounce_row_n80", tr_row[80], 4'hF);
    check("bounce_row_n83", tr_row[83], 4'h7);
    check("bounce_row_n86", tr_row[86], 4'hF);
    check("bounce_row_n89", tr_row[89], 4'h7);
    check("bounce_row_n92", tr_row[92], 4'hF);
    check("bounce_row_n95", tr_row[95], 4'hF);
    check("bounce_busy_n109", tr_busy[109], 1'b1);
    check("bounce_busy_n110", tr_busy[110], 1'b0);
    check("bounce_done_n110", tr_done[110], 1'b1);
    busy_cnt = 0;
    for (int n = 0; n <= 111; n++) if (tr_busy[n]) busy_cnt++;
    check("bounce_busy_cycles", busy_cnt, 110);
    tick();

    // Reset asserted in the middle of HELD.
    press(0, 4'h1);
    repeat (30) tick();
    check("held_before_reset", row[0], 4'h7);
    #2 reset = 1'b1;
    #1;
    check("reset_mid_row", row[0], 4'hF);
    check("reset_mid_busy", busy[0], 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("after_reset_row", row[0], 4'hF);
    check("after_reset_busy", busy[0], 1'b0);

    // Every code against a rotating column scan (4 cycles per column).
    ph = 0;
    for (int k = 0; k < 16; k++) begin
      hits        = 0;
      key_req[0]  = 1'b1;
      key_code[0] = 4'(k);
      for (int n = 0; n <= busy_len(0) + 1; n++) begin
        col[0] = 4'(~(4'b0001 << ((ph / 4) % 4)));
        sent   = col[0];
        ph++;
        tick();
        key_req[0] = 1'b0;
        if (row[0] != 4'hF) begin
          hits++;
          check("scan_key", key_at(sent, row[0]), k);
        end
      end
      check("scan_hits_nonzero", hits > 0, 1'b1);
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
